// File: rtl/circle_draw_ctrl.sv
// Circle drawing sequencer: walks a segment ROM, hands each segment's endpoints
// to an external line drawer and waits for it, one full circle per pass.
module circle_draw_ctrl #(
    parameter int NUM_SEGS = 36,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          continuous,
    output logic [5:0]    rom_addr,
    input  logic [CW-1:0] rom_x0,
    input  logic [CW-1:0] rom_y0,
    input  logic [CW-1:0] rom_x1,
    input  logic [CW-1:0] rom_y1,
    output logic [CW-1:0] line_x0,
    output logic [CW-1:0] line_y0,
    output logic [CW-1:0] line_x1,
    output logic [CW-1:0] line_y1,
    output logic          line_start,
    input  logic          line_done,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        NEXT   = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [5:0] LAST_ADDR = 6'(NUM_SEGS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] addr_nxt;
    logic       load_line;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rom_addr <= '0;
        end else begin
            state    <= state_nxt;
            rom_addr <= addr_nxt;
        end
    end

    // Endpoints only move on the FETCH edge, so the drawer sees stable inputs
    // from LAUNCH until it reports completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_x0 <= '0;
            line_y0 <= '0;
            line_x1 <= '0;
            line_y1 <= '0;
        end else if (load_line) begin
            line_x0 <= rom_x0;
            line_y0 <= rom_y0;
            line_x1 <= rom_x1;
            line_y1 <= rom_y1;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        load_line = 1'b0;
        // abort outranks every other input once a pass is under way
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = FETCH;
                        addr_nxt  = '0;
                    end
                end
                FETCH: begin
                    load_line = 1'b1;
                    state_nxt = LAUNCH;
                end
                LAUNCH: begin
                    state_nxt = WAIT;
                end
                WAIT: begin
                    if (line_done) begin
                        state_nxt = NEXT;
                    end
                end
                NEXT: begin
                    if (rom_addr < LAST_ADDR) begin
                        addr_nxt  = rom_addr + 6'd1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = FIN;
                    end
                end
                FIN: begin
                    addr_nxt  = '0;
                    state_nxt = continuous ? FETCH : IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    addr_nxt  = '0;
                end
            endcase
        end
    end

    assign line_start = (state == LAUNCH);
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);

endmodule

// File: tb/tb_circle_draw_ctrl.sv
// Scoreboard bench for circle_draw_ctrl: a ROM model, a line-drawer responder,
// directed passes, and a monitor popping expected segments/done pulses.
module tb_circle_draw_ctrl;

    localparam int CW   = 11;
    localparam int NSEG = 36;

    logic          clk;
    logic          reset_n;
    logic          start_stim;
    logic          start_noise;
    logic          abort;
    logic          continuous;
    logic [5:0]    rom_addr;
    logic [CW-1:0] rom_x0, rom_y0, rom_x1, rom_y1;
    logic [CW-1:0] line_x0, line_y0, line_x1, line_y1;
    logic          line_start;
    logic          line_done;
    logic          busy;
    logic          done;

    circle_draw_ctrl #(.NUM_SEGS(NSEG), .CW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_stim | start_noise),
        .abort      (abort),
        .continuous (continuous),
        .rom_addr   (rom_addr),
        .rom_x0     (rom_x0),
        .rom_y0     (rom_y0),
        .rom_x1     (rom_x1),
        .rom_y1     (rom_y1),
        .line_x0    (line_x0),
        .line_y0    (line_y0),
        .line_x1    (line_x1),
        .line_y1    (line_y1),
        .line_start (line_start),
        .line_done  (line_done),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Circle points: 0, 1 and 35 are the known endpoints; the rest are just distinct.
    int px[0:NSEG-1];
    int py[0:NSEG-1];

    always_comb begin
        rom_x0 = CW'(px[int'(rom_addr) % NSEG]);
        rom_y0 = CW'(py[int'(rom_addr) % NSEG]);
        rom_x1 = CW'(px[(int'(rom_addr) + 1) % NSEG]);
        rom_y1 = CW'(py[(int'(rom_addr) + 1) % NSEG]);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        bit is_done;
        int addr;
        int x0, y0, x1, y1;
        bit busy_after;
    } exp_t;

    exp_t q[$];

    task automatic push_segs(input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.is_done    = 1'b0;
            e.addr       = k;
            e.x0         = px[k];
            e.y0         = py[k];
            e.x1         = px[(k + 1) % NSEG];
            e.y1         = py[(k + 1) % NSEG];
            e.busy_after = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic push_done(input bit busy_after);
        exp_t e;
        e.is_done    = 1'b1;
        e.addr       = 0;
        e.x0         = 0;
        e.y0         = 0;
        e.x1         = 0;
        e.y1         = 0;
        e.busy_after = busy_after;
        q.push_back(e);
    endtask

    // Line-drawer model: line_done 5 cycles after each line_start; in noise mode
    // it also holds line_done through NEXT/FETCH/LAUNCH and pokes start during WAIT.
    bit noise_mode   = 1'b0;
    bit hold_active  = 1'b0;
    int resp_cnt     = 0;
    int last_ld_edge = -100;

    initial begin
        line_done   = 1'b0;
        start_noise = 1'b0;
        forever begin
            @(negedge clk);
            start_noise = 1'b0;
            if (!reset_n) begin
                resp_cnt    = 0;
                line_done   = 1'b0;
                hold_active = 1'b0;
            end else begin
                if (hold_active) begin
                    if (line_start || done) begin
                        hold_active = 1'b0;
                        line_done   = 1'b0;
                    end
                end else begin
                    line_done = 1'b0;
                end
                if (line_start) begin
                    resp_cnt = 5;
                end else if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (noise_mode && resp_cnt == 3) start_noise = 1'b1;
                    if (resp_cnt == 0) begin
                        line_done    = 1'b1;
                        last_ld_edge = cyc + 1;
                        hold_active  = noise_mode;
                    end
                end
            end
        end
    end

    // Monitor
    int ls_count       = 0;
    int done_count     = 0;
    int exp_ls_cyc     = -1;
    bit chk_busy_after = 1'b0;
    bit exp_busy_after = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (chk_busy_after) begin
                    check("busy_after_done", busy, exp_busy_after);
                    chk_busy_after = 1'b0;
                end
                if (line_start) begin
                    ls_count++;
                    if (exp_ls_cyc >= 0) begin
                        check("start_to_line_start_latency", cyc, exp_ls_cyc);
                        exp_ls_cyc = -1;
                    end
                    if (q.size() == 0) begin
                        check("unexpected_line_start", ls_count, 0);
                    end else begin
                        e = q.pop_front();
                        check("event_kind_line", 0, e.is_done);
                        check("seg_addr", rom_addr, e.addr);
                        check("seg_x0", line_x0, e.x0);
                        check("seg_y0", line_y0, e.y0);
                        check("seg_x1", line_x1, e.x1);
                        check("seg_y1", line_y1, e.y1);
                    end
                end
                if (done) begin
                    done_count++;
                    check("line_done_to_done_latency", cyc, last_ld_edge + 1);
                    if (q.size() == 0) begin
                        check("unexpected_done", done_count, 0);
                    end else begin
                        e = q.pop_front();
                        check("event_kind_done", 1, e.is_done);
                        chk_busy_after = 1'b1;
                        exp_busy_after = e.busy_after;
                    end
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start_stim = 1'b1;
        exp_ls_cyc = cyc + 2;
        @(negedge clk);
        start_stim = 1'b0;
    endtask

    task automatic wait_ls(input int target, input string name);
        int n = 0;
        while (ls_count < target && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, ls_count, target);
    endtask

    task automatic wait_done(input int target, input string name, output int busy_low);
        int n = 0;
        busy_low = 0;
        while (done_count < target && n < 3000) begin
            @(negedge clk);
            #1;
            if (!busy) busy_low++;
            n++;
        end
        check(name, done_count, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_line_start"}, line_start, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_line_coords"}, {line_x0, line_y0, line_x1, line_y1}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bl1, bl2, bl3;
        for (int k = 0; k < NSEG; k++) begin
            px[k] = 300 + 3 * k;
            py[k] = 100 + 7 * k;
        end
        px[0]  = 420; py[0]  = 240;
        px[1]  = 417; py[1]  = 257;
        px[35] = 417; py[35] = 222;

        reset_n    = 1'b1;
        start_stim = 1'b0;
        abort      = 1'b0;
        continuous = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("idle_busy_after_reset", busy, 0);
        check("idle_no_line_start", ls_count, 0);

        // Plain full pass
        push_segs(NSEG);
        push_done(1'b0);
        do_start();
        wait_done(1, "pass1_done", bl1);
        repeat (3) @(negedge clk);
        #1;
        check("pass1_line_starts", ls_count, 36);
        check("pass1_queue_drained", q.size(), 0);

        // Stray start during WAIT, line_done held high outside WAIT
        noise_mode = 1'b1;
        push_segs(NSEG);
        push_done(1'b0);
        do_start();
        wait_done(2, "noise_done", bl1);
        repeat (3) @(negedge clk);
        noise_mode = 1'b0;
        #1;
        check("noise_line_starts", ls_count, 72);
        check("noise_queue_drained", q.size(), 0);

        // Abort in WAIT of segment 17
        push_segs(18);
        do_start();
        wait_ls(90, "abort_reach_seg17");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rom_addr", rom_addr, 0);
        check("abort_done", done, 0);
        repeat (10) @(negedge clk);
        #1;
        check("abort_no_done", done_count, 2);
        check("abort_no_repeat", ls_count, 90);
        check("abort_queue_drained", q.size(), 0);

        // Redraw after abort starts again from address 0
        push_segs(NSEG);
        push_done(1'b0);
        do_start();
        wait_done(3, "redraw_done", bl1);
        repeat (3) @(negedge clk);
        #1;
        check("redraw_line_starts", ls_count, 126);

        // Continuous: two back-to-back passes
        continuous = 1'b1;
        push_segs(NSEG);
        push_done(1'b1);
        push_segs(NSEG);
        push_done(1'b0);
        do_start();
        wait_done(4, "cont_done1", bl2);
        @(negedge clk);
        continuous = 1'b0;
        wait_done(5, "cont_done2", bl3);
        check("cont_busy_never_low", bl2 + bl3, 0);
        repeat (3) @(negedge clk);
        #1;
        check("cont_line_starts", ls_count, 198);
        check("cont_queue_drained", q.size(), 0);

        // Asynchronous reset during segment 9
        push_segs(10);
        do_start();
        wait_ls(208, "reset_reach_seg9");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("midpass_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("post_reset_no_line_start", ls_count, 208);
        check("post_reset_idle", busy, 0);
        check("post_reset_no_done", done_count, 5);
        check("post_reset_queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
